// File: rtl/toggle_pulse_debouncer_if.sv
// Button-side signal bundle for the toggle/preset debouncer.
// The master drives the raw button and enable. The slave returns the pulses and the status.
interface toggle_pulse_debouncer_if;
    logic btn_raw;
    logic enable;
    logic T;
    logic preset;
    logic btn_level;
    logic busy;

    modport master (
        output btn_raw,
        output enable,
        input  T,
        input  preset,
        input  btn_level,
        input  busy
    );

    modport slave (
        input  btn_raw,
        input  enable,
        output T,
        output preset,
        output btn_level,
        output busy
    );
endinterface

// File: rtl/toggle_pulse_debouncer.sv
// Debounces a raw push-button. Each press yields one T pulse.
// A long hold also yields one preset pulse, both for the downstream T flip-flop.
module toggle_pulse_debouncer #(
    parameter int unsigned STABLE_CYCLES     = 16,
    parameter int unsigned LONG_PRESS_CYCLES = 64,
    parameter int unsigned CNT_W             = 8
) (
    input logic                    Clock,
    input logic                    reset,
    toggle_pulse_debouncer_if.slave io
);

    typedef enum logic [1:0] {IDLE, SHORT, HELD} state_t;

    state_t            state, state_next;
    logic              sync1, sync;
    logic              btn_level;
    logic [CNT_W-1:0]  stab_cnt;
    logic [CNT_W-1:0]  hold_cnt;
    logic              was_held;

    // Two-flop synchronizer followed by the stability counter.
    always_ff @(posedge Clock) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync      <= 1'b0;
            btn_level <= 1'b0;
            stab_cnt  <= '0;
        end else begin
            sync1 <= io.btn_raw;
            sync  <= sync1;
            if (sync == btn_level) begin
                stab_cnt <= '0;
            end else if (stab_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                btn_level <= sync;
                stab_cnt  <= '0;
            end else if (stab_cnt != '1) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
        end
    end

    // State register. hold_cnt is zero on the first SHORT cycle and stays frozen in HELD.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            was_held <= 1'b0;
        end else begin
            state    <= state_next;
            was_held <= (state == HELD);
            if (state_next == IDLE || state == IDLE) begin
                hold_cnt <= '0;
            end else if (state == SHORT && hold_cnt != '1) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (btn_level) state_next = SHORT;
            SHORT: begin
                if (!btn_level)
                    state_next = IDLE;
                else if (hold_cnt == CNT_W'(LONG_PRESS_CYCLES - 1))
                    state_next = HELD;
            end
            HELD:    if (!btn_level) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pulses are gated by enable in the cycle they occur, so a pulse masked by enable is lost.
    always_comb begin
        io.T         = (state == SHORT) && (hold_cnt == '0) && io.enable;
        io.preset    = (state == HELD) && !was_held && io.enable;
        io.busy      = (state != IDLE);
        io.btn_level = btn_level;
    end

endmodule

// File: tb/tb_toggle_pulse_debouncer.sv
// Bench for toggle_pulse_debouncer: a level-history reference model, directed scenarios, random stimulus.
module tb_toggle_pulse_debouncer;
    localparam int S = 16;
    localparam int L = 64;

    logic Clock = 1'b0;
    logic reset = 1'b1;
    always #5 Clock = ~Clock;

    toggle_pulse_debouncer_if bus();

    toggle_pulse_debouncer #(
        .STABLE_CYCLES(S),
        .LONG_PRESS_CYCLES(L),
        .CNT_W(8)
    ) dut (
        .Clock(Clock),
        .reset(reset),
        .io(bus)
    );

    int errors = 0;
    int checks = 0;
    int ecnt = 0;
    int t_count = 0, p_count = 0, t_edge = 0, p_edge = 0;
    int press_edge = 0;
    logic chk_on = 1'b0;
    logic q = 1'b0;

    // Model: sync history, debounced level, and the history of that level.
    logic         m_s1 = 0, m_sync = 0, m_level = 0;
    logic [S-1:0] sh = '0;
    logic [L+2:0] lh = '0;
    logic [S-1:0] sh_n;
    logic         nl;

    always @(posedge Clock) begin
        ecnt <= ecnt + 1;
        if (reset) begin
            m_s1 <= 0; m_sync <= 0; m_level <= 0; sh <= '0; lh <= '0;
        end else begin
            m_s1   <= bus.btn_raw;
            m_sync <= m_s1;
            sh_n = {sh[S-2:0], m_sync};
            nl = (sh_n == {S{~m_level}}) ? ~m_level : m_level;
            sh      <= sh_n;
            m_level <= nl;
            lh      <= {lh[L+1:0], nl};
        end
    end

    // T flip-flop downstream of the debouncer
    always @(posedge Clock) begin
        if (reset) q <= 1'b0;
        else if (bus.preset) q <= 1'b1;
        else if (bus.T) q <= ~q;
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_on) begin
            check("btn_level", bus.btn_level, lh[0]);
            check("busy",      bus.busy,      lh[1]);
            check("T",         bus.T,         bus.enable & lh[1] & ~lh[2]);
            check("preset",    bus.preset,    bus.enable & (&lh[L+1:1]) & ~lh[L+2]);
            if (bus.T) begin t_count++; t_edge = ecnt; end
            if (bus.preset) begin p_count++; p_edge = ecnt; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic clear_counts();
        t_count = 0; p_count = 0; t_edge = 0; p_edge = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_raw = 1'b0;
        bus.enable  = 1'b1;
        reset = 1'b1;
        tick(1);
        chk_on = 1'b1;
        tick(3);
        check("reset_T", bus.T, 1'b0);
        check("reset_preset", bus.preset, 1'b0);
        check("reset_level", bus.btn_level, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        reset = 1'b0;
        tick(5);

        // Clean 40-cycle press
        clear_counts();
        press_edge = ecnt + 1;
        bus.btn_raw = 1'b1; tick(40);
        bus.btn_raw = 1'b0; tick(40);
        check_int("clean_tcount", t_count, 1);
        check_int("clean_latency", t_edge - press_edge + 1, S + 3);
        check_int("clean_pcount", p_count, 0);

        // Bouncy press: toggle every 3 cycles, then stable high
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw = ~bus.btn_raw; tick(3);
        end
        check_int("bounce_tcount", t_count, 0);
        press_edge = ecnt + 1;
        bus.btn_raw = 1'b1; tick(50);
        bus.btn_raw = 1'b0; tick(40);
        check_int("bounce_tcount_end", t_count, 1);
        check_int("bounce_latency", t_edge - press_edge + 1, S + 3);

        // Long press
        clear_counts();
        bus.btn_raw = 1'b1; tick(200);
        bus.btn_raw = 1'b0; tick(40);
        check_int("long_tcount", t_count, 1);
        check_int("long_pcount", p_count, 1);
        check_int("long_gap", p_edge - t_edge, L);
        check("long_busy_after", bus.busy, 1'b0);

        // enable low for a whole press, then raised mid-hold
        clear_counts();
        bus.enable = 1'b0;
        bus.btn_raw = 1'b1; tick(50);
        check("dis_level", bus.btn_level, 1'b1);
        check("dis_busy", bus.busy, 1'b1);
        tick(50);
        bus.btn_raw = 1'b0; tick(40);
        bus.btn_raw = 1'b1; tick(30);
        bus.enable = 1'b1; tick(20);
        bus.btn_raw = 1'b0; tick(40);
        check_int("dis_tcount", t_count, 0);
        check_int("dis_pcount", p_count, 0);

        // Reset mid-press, released with the button held
        bus.btn_raw = 1'b1; tick(10);
        reset = 1'b1; tick(3);
        check("rst_T", bus.T, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_level", bus.btn_level, 1'b0);
        clear_counts();
        press_edge = ecnt + 1;
        reset = 1'b0; tick(40);
        bus.btn_raw = 1'b0; tick(40);
        check_int("rst_tcount", t_count, 1);
        check_int("rst_latency", t_edge - press_edge + 1, S + 3);
        check_int("rst_pcount", p_count, 0);

        // Closed loop with the T flip-flop
        reset = 1'b1; tick(2); reset = 1'b0; tick(2);
        bus.btn_raw = 1'b1; tick(30); bus.btn_raw = 1'b0; tick(40);
        check("loop_q1", q, 1'b1);
        bus.btn_raw = 1'b1; tick(30); bus.btn_raw = 1'b0; tick(40);
        check("loop_q2", q, 1'b0);
        bus.btn_raw = 1'b1; tick(30); bus.btn_raw = 1'b0; tick(40);
        check("loop_q3", q, 1'b1);
        bus.btn_raw = 1'b1; tick(100); bus.btn_raw = 1'b0; tick(40);
        check("loop_q_long", q, 1'b1);

        // Random stimulus checked against the model
        for (int seg = 0; seg < 60; seg++) begin
            bus.btn_raw = 1'($urandom_range(0, 1));
            bus.enable  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1; tick(2); reset = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 20));
            else tick($urandom_range(20, 120));
        end
        bus.btn_raw = 1'b0;
        tick(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
